// File: rtl/uart_prog_loader.sv
// UART program loader: 8N1 receiver packs byte pairs into 16-bit words for a 256x16
// program memory; a debounced button toggles LOAD (UART writes) and RUN (fetch reads).
module uart_prog_loader #(
    parameter int CLKS_PER_BIT    = 434,
    parameter int DEBOUNCE_CYCLES = 1000000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        rx,
    input  logic        button,
    input  logic [7:0]  addrPC,
    output logic [15:0] dataOut,
    output logic        mode,
    output logic [8:0]  word_count,
    output logic        frame_err
);
    localparam int BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [BW-1:0] FULL = BW'(CLKS_PER_BIT - 1);
    localparam logic [BW-1:0] HALF = BW'((CLKS_PER_BIT / 2 > 0) ? CLKS_PER_BIT / 2 - 1 : 0);
    localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [DW-1:0] DB_LAST = DW'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} rx_state_e;

    logic [1:0]    rx_sync_q, btn_sync_q;
    logic          rx_s, btn_s;
    rx_state_e     state_q, state_d;
    logic [BW-1:0] baud_q, baud_d;
    logic [2:0]    bit_q, bit_d;
    logic [7:0]    shift_q, shift_d;
    logic          bv_q, bv_d, ferr_set;
    logic          db_q, db_d, toggle;
    logic [DW-1:0] dbcnt_q, dbcnt_d;
    logic          mode_q, mode_d, phase_q, phase_d, ferr_q, ferr_d, we;
    logic [7:0]    wr_q, wr_d, hi_q, hi_d;
    logic [8:0]    wc_q, wc_d;
    logic [15:0]   dout_q;
    logic [15:0]   mem [256];

    assign rx_s  = rx_sync_q[1];
    assign btn_s = btn_sync_q[1];

    always_comb begin
        state_d  = state_q;
        baud_d   = baud_q;
        bit_d    = bit_q;
        shift_d  = shift_q;
        bv_d     = 1'b0;
        ferr_set = 1'b0;
        case (state_q)
            S_IDLE: if (!rx_s) begin
                state_d = S_START;
                baud_d  = HALF;
            end
            S_START: begin
                if (baud_q != '0) baud_d = baud_q - BW'(1);
                else if (!rx_s) begin
                    state_d = S_DATA;
                    baud_d  = FULL;
                    bit_d   = 3'd0;
                end else state_d = S_IDLE;
            end
            S_DATA: begin
                if (baud_q != '0) baud_d = baud_q - BW'(1);
                else begin
                    shift_d = {rx_s, shift_q[7:1]};
                    baud_d  = FULL;
                    if (bit_q == 3'd7) state_d = S_STOP;
                    else bit_d = bit_q + 3'd1;
                end
            end
            S_STOP: begin
                if (baud_q != '0) baud_d = baud_q - BW'(1);
                else begin
                    state_d = S_IDLE;
                    if (rx_s) bv_d = 1'b1;
                    else ferr_set = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Level is accepted only once it has differed from the current one for DEBOUNCE_CYCLES samples.
    always_comb begin
        db_d    = db_q;
        dbcnt_d = '0;
        if (btn_s != db_q) begin
            if (dbcnt_q == DB_LAST) db_d = btn_s;
            else dbcnt_d = dbcnt_q + DW'(1);
        end
    end
    assign toggle = db_q & ~db_d;

    // A toggle pre-empts any byte completing in the same cycle and drops a pending high byte.
    always_comb begin
        mode_d  = mode_q;
        phase_d = phase_q;
        wr_d    = wr_q;
        hi_d    = hi_q;
        wc_d    = wc_q;
        ferr_d  = ferr_q | ferr_set;
        we      = 1'b0;
        if (toggle) begin
            mode_d  = ~mode_q;
            phase_d = 1'b0;
            if (!mode_q) begin
                wr_d   = 8'd0;
                wc_d   = 9'd0;
                ferr_d = 1'b0;
            end
        end else if (mode_q && bv_q) begin
            if (!phase_q) begin
                hi_d    = shift_q;
                phase_d = 1'b1;
            end else begin
                we      = 1'b1;
                wr_d    = wr_q + 8'd1;
                phase_d = 1'b0;
                if (wc_q != 9'd256) wc_d = wc_q + 9'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rx_sync_q  <= 2'b11;
            btn_sync_q <= 2'b11;
            state_q    <= S_IDLE;
            baud_q     <= '0;
            bit_q      <= 3'd0;
            shift_q    <= 8'd0;
            bv_q       <= 1'b0;
            db_q       <= 1'b1;
            dbcnt_q    <= '0;
            mode_q     <= 1'b1;
            phase_q    <= 1'b0;
            wr_q       <= 8'd0;
            hi_q       <= 8'd0;
            wc_q       <= 9'd0;
            ferr_q     <= 1'b0;
            dout_q     <= 16'h0000;
        end else begin
            rx_sync_q  <= {rx_sync_q[0], rx};
            btn_sync_q <= {btn_sync_q[0], button};
            state_q    <= state_d;
            baud_q     <= baud_d;
            bit_q      <= bit_d;
            shift_q    <= shift_d;
            bv_q       <= bv_d;
            db_q       <= db_d;
            dbcnt_q    <= dbcnt_d;
            mode_q     <= mode_d;
            phase_q    <= phase_d;
            wr_q       <= wr_d;
            hi_q       <= hi_d;
            wc_q       <= wc_d;
            ferr_q     <= ferr_d;
            dout_q     <= mode_q ? 16'h0000 : mem[addrPC];
        end
    end

    always_ff @(posedge clk) begin
        if (we) mem[wr_q] <= {hi_q, shift_q};
    end

    assign dataOut    = dout_q;
    assign mode       = mode_q;
    assign word_count = wc_q;
    assign frame_err  = ferr_q;
endmodule

// File: tb/tb_uart_prog_loader.sv
// Bench for uart_prog_loader: vector table, directed corner sequences, then
// randomized actions checked against a word-level model of the loader.
module tb_uart_prog_loader;
    localparam int CPB = 4;
    localparam int DB  = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        rx = 1'b1;
    logic        button = 1'b1;
    logic [7:0]  addrPC = 8'd0;
    logic [15:0] dataOut;
    logic        mode;
    logic [8:0]  word_count;
    logic        frame_err;

    int checks = 0;
    int failures = 0;

    uart_prog_loader #(.CLKS_PER_BIT(CPB), .DEBOUNCE_CYCLES(DB)) dut (
        .clk(clk), .reset(reset), .rx(rx), .button(button), .addrPC(addrPC),
        .dataOut(dataOut), .mode(mode), .word_count(word_count), .frame_err(frame_err)
    );

    always #5 clk = ~clk;

    initial begin
        #3000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    // Reference model: loader behaviour stated in terms of words and counts.
    logic        m_mode, m_phase, m_fe;
    logic [7:0]  m_hi;
    int          m_wr, m_wc;
    logic [15:0] m_mem [256];
    bit          m_known [256];

    typedef struct {
        int          kind;    // 0 send byte, 1 press, 2 read
        logic [7:0]  arg;
        logic        stopb;
        logic        exp_mode;
        logic [8:0]  exp_wc;
        logic        exp_fe;
        logic [15:0] exp_data;
    } vec_t;
    vec_t tbl [14];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        rx = 1'b1;
        button = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stopb);
        rx = 1'b0;
        repeat (CPB) tick();
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (CPB) tick();
        end
        rx = stopb;
        repeat (CPB) tick();
        rx = 1'b1;
        repeat (3 * CPB) tick();
    endtask

    task automatic press();
        button = 1'b0;
        repeat (DB + 6) tick();
        button = 1'b1;
        repeat (DB + 6) tick();
    endtask

    task automatic read_chk(input string nm, input logic [7:0] a, input logic [15:0] exp);
        addrPC = a;
        tick();
        chk(nm, dataOut, exp);
    endtask

    task automatic rx_glitch();
        rx = 1'b0;
        repeat (2) tick();
        rx = 1'b1;
        repeat (3 * CPB) tick();
    endtask

    task automatic btn_glitches();
        for (int i = 0; i < 3; i++) begin
            button = 1'b0;
            tick();
            button = 1'b1;
            repeat (6) tick();
        end
    endtask

    task automatic chk_state(input string nm, input logic em, input logic [8:0] ewc, input logic efe);
        chk({nm, ".mode"}, mode, em);
        chk({nm, ".word_count"}, word_count, ewc);
        chk({nm, ".frame_err"}, frame_err, efe);
    endtask

    task automatic model_reset();
        m_mode = 1'b1; m_phase = 1'b0; m_fe = 1'b0; m_wr = 0; m_wc = 0; m_hi = 8'd0;
    endtask

    task automatic model_byte(input logic [7:0] b, input logic stopb);
        if (!stopb) m_fe = 1'b1;
        else if (m_mode) begin
            if (!m_phase) begin
                m_hi = b;
                m_phase = 1'b1;
            end else begin
                m_mem[m_wr] = {m_hi, b};
                m_known[m_wr] = 1'b1;
                m_wr = (m_wr + 1) % 256;
                m_wc = (m_wc < 256) ? m_wc + 1 : 256;
                m_phase = 1'b0;
            end
        end
    endtask

    task automatic model_press();
        m_mode = ~m_mode;
        m_phase = 1'b0;
        if (m_mode) begin
            m_wr = 0; m_wc = 0; m_fe = 1'b0;
        end
    endtask

    initial begin
        tbl[0]  = '{0, 8'h12, 1'b1, 1'b1, 9'd0, 1'b0, 16'h0};
        tbl[1]  = '{0, 8'h34, 1'b1, 1'b1, 9'd1, 1'b0, 16'h0};
        tbl[2]  = '{0, 8'hAB, 1'b1, 1'b1, 9'd1, 1'b0, 16'h0};
        tbl[3]  = '{0, 8'hCD, 1'b1, 1'b1, 9'd2, 1'b0, 16'h0};
        tbl[4]  = '{1, 8'h00, 1'b1, 1'b0, 9'd2, 1'b0, 16'h0};
        tbl[5]  = '{2, 8'h00, 1'b1, 1'b0, 9'd2, 1'b0, 16'h1234};
        tbl[6]  = '{2, 8'h01, 1'b1, 1'b0, 9'd2, 1'b0, 16'hABCD};
        tbl[7]  = '{1, 8'h00, 1'b1, 1'b1, 9'd0, 1'b0, 16'h0};
        tbl[8]  = '{0, 8'h55, 1'b0, 1'b1, 9'd0, 1'b1, 16'h0};
        tbl[9]  = '{0, 8'h01, 1'b1, 1'b1, 9'd0, 1'b1, 16'h0};
        tbl[10] = '{0, 8'h02, 1'b1, 1'b1, 9'd1, 1'b1, 16'h0};
        tbl[11] = '{1, 8'h00, 1'b1, 1'b0, 9'd1, 1'b1, 16'h0};
        tbl[12] = '{2, 8'h00, 1'b1, 1'b0, 9'd1, 1'b1, 16'h0102};
        tbl[13] = '{2, 8'h01, 1'b1, 1'b0, 9'd1, 1'b1, 16'hABCD};

        do_reset();
        chk_state("reset", 1'b1, 9'd0, 1'b0);
        chk("reset.dataOut", dataOut, 16'h0000);
        repeat (4) tick();

        for (int v = 0; v < 14; v++) begin
            case (tbl[v].kind)
                0: send_byte(tbl[v].arg, tbl[v].stopb);
                1: press();
                default: read_chk($sformatf("tbl%0d.dataOut", v), tbl[v].arg, tbl[v].exp_data);
            endcase
            chk_state($sformatf("tbl%0d", v), tbl[v].exp_mode, tbl[v].exp_wc, tbl[v].exp_fe);
        end

        // Glitches on rx and button must not disturb the loader.
        press();
        chk_state("reload", 1'b1, 9'd0, 1'b0);
        rx_glitch();
        chk_state("rxglitch", 1'b1, 9'd0, 1'b0);
        send_byte(8'hA5, 1'b1);
        rx_glitch();
        send_byte(8'h5A, 1'b1);
        chk_state("afterglitch", 1'b1, 9'd1, 1'b0);
        btn_glitches();
        chk_state("btnglitch", 1'b1, 9'd1, 1'b0);

        // 257 words: counter saturates, address wraps and word 256 overwrites word 0.
        press();
        press();
        for (int i = 0; i < 257; i++) begin
            logic [7:0] lo8;
            lo8 = i[7:0];
            send_byte(lo8, 1'b1);
            send_byte(~lo8, 1'b1);
        end
        chk_state("wrap", 1'b1, 9'd256, 1'b0);
        press();
        read_chk("wrap.mem0", 8'd0, 16'h00FF);
        read_chk("wrap.mem1", 8'd1, 16'h01FE);
        read_chk("wrap.mem255", 8'd255, 16'hFF00);

        // Pending high byte is dropped by a double toggle.
        press();
        send_byte(8'h77, 1'b1);
        press();
        press();
        send_byte(8'h11, 1'b1);
        send_byte(8'h22, 1'b1);
        chk_state("pending", 1'b1, 9'd1, 1'b0);
        read_chk("pending.loadblank", 8'd0, 16'h0000);
        press();
        read_chk("pending.mem0", 8'd0, 16'h1122);

        // Reset in the middle of a frame.
        rx = 1'b0;
        repeat (CPB) tick();
        rx = 1'b1;
        repeat (CPB) tick();
        rx = 1'b0;
        repeat (3) tick();
        reset = 1'b1;
        rx = 1'b1;
        tick();
        reset = 1'b0;
        chk_state("midreset", 1'b1, 9'd0, 1'b0);
        chk("midreset.dataOut", dataOut, 16'h0000);
        repeat (15 * CPB) tick();
        send_byte(8'hDE, 1'b1);
        send_byte(8'hAD, 1'b1);
        chk_state("dead", 1'b1, 9'd1, 1'b0);
        press();
        read_chk("dead.mem0", 8'd0, 16'hDEAD);

        // Randomized actions against the model.
        do_reset();
        model_reset();
        for (int i = 0; i < 256; i++) m_known[i] = 1'b0;
        repeat (4) tick();
        for (int n = 0; n < 80; n++) begin
            int sel;
            sel = $urandom_range(0, 9);
            if (sel <= 5) begin
                logic [7:0] b;
                logic sb;
                b = 8'($urandom);
                sb = ($urandom_range(0, 9) != 0);
                send_byte(b, sb);
                model_byte(b, sb);
            end else if (sel == 6) begin
                press();
                model_press();
            end else if (sel <= 8) begin
                logic [7:0] a;
                a = ($urandom_range(0, 1) == 0) ? 8'($urandom_range(0, 3)) : 8'($urandom);
                if (m_mode) read_chk($sformatf("rnd%0d.blank", n), a, 16'h0000);
                else if (m_known[a]) read_chk($sformatf("rnd%0d.read", n), a, m_mem[a]);
            end else begin
                rx_glitch();
                btn_glitches();
            end
            chk_state($sformatf("rnd%0d", n), m_mode, 9'(m_wc), m_fe);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
